// File: rtl/word_memory_sequencer.sv
// word_memory_sequencer: moves one DATA_W-bit word to or from a byte-wide memory.
// A store is split into DATA_W/8 byte writes, and a load is built from DATA_W/8 byte reads.
// Byte addresses count up from a base address and wrap modulo 2**ADDR_W.
// Byte order and memory read latency are set by parameters.
// All memory-side outputs are registered.
module word_memory_sequencer #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 16,
  parameter bit LITTLE_ENDIAN = 1'b1,
  parameter int MEM_RD_LAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [7:0]        mem_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              addr_wrap,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic [7:0]        mem_data
);

  localparam int NB = DATA_W / 8;
  // cyc_reg counts through the XFER cycles and then the DRAIN cycles, so it must hold NB+MEM_RD_LAT.
  localparam int CW = $clog2(NB + MEM_RD_LAT + 1) + 1;
  localparam logic [CW-1:0]     LAST_XFER  = CW'(NB - 1);
  localparam logic [CW-1:0]     LAST_DRAIN = CW'(NB + MEM_RD_LAT - 1);
  localparam logic [CW-1:0]     CAP_FIRST  = CW'(MEM_RD_LAT);
  localparam logic [ADDR_W-1:0] ADDR_ONES  = '1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t            state_reg;
  logic              op_reg;
  logic [DATA_W-1:0] word_reg;
  logic [CW-1:0]     cyc_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              addr_wrap_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic              mem_cs_reg;
  logic              mem_wr_reg;
  logic [7:0]        mem_data_reg;

  logic [7:0]        shadow_lane [NB];
  logic [DATA_W-1:0] shadow_word;
  logic              cap_en;
  logic [CW-1:0]     cap_idx;

  // Returns the byte that goes to address Base+idx, taking byte order into account.
  function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] w, input logic [CW-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < NB; k++) begin
      if (idx == CW'(k)) b = LITTLE_ENDIAN ? w[8*k +: 8] : w[8*(NB-1-k) +: 8];
    end
    return b;
  endfunction

  // Read data for index i shows up MEM_RD_LAT cycles after its address was issued.
  // Using cyc_reg+1 > CAP_FIRST means the compare is never a constant when the latency is 0.
  assign cap_en  = !op_reg && (state_reg == XFER || state_reg == DRAIN) &&
                   ((cyc_reg + 1'b1) > CAP_FIRST);
  assign cap_idx = cyc_reg - CAP_FIRST;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      localparam logic [CW-1:0] LANE_IDX = LITTLE_ENDIAN ? CW'(gi) : CW'(NB - 1 - gi);
      // Shadow byte lane: takes its byte when the incoming byte index matches this lane.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             shadow_lane[gi] <= '0;
        else if (cap_en && cap_idx == LANE_IDX) shadow_lane[gi] <= mem_out;
      end
      assign shadow_word[8*gi +: 8] = shadow_lane[gi];
    end
  endgenerate

  // Transfer FSM. It produces every output as a register, from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      op_reg          <= 1'b0;
      word_reg        <= '0;
      cyc_reg         <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      rd_data_reg     <= '0;
      addr_wrap_reg   <= 1'b0;
      mem_address_reg <= '0;
      mem_cs_reg      <= 1'b1;
      mem_wr_reg      <= 1'b0;
      mem_data_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          // If abort arrives in the same cycle as start, the request is dropped.
          if (start && !abort) begin
            state_reg       <= XFER;
            op_reg          <= op;
            word_reg        <= wr_data;
            addr_wrap_reg   <= 1'b0;
            cyc_reg         <= '0;
            busy_reg        <= 1'b1;
            mem_address_reg <= base_addr;
            mem_cs_reg      <= 1'b0;
            mem_wr_reg      <= op;
            mem_data_reg    <= op ? word_byte(wr_data, '0) : 8'h00;
          end
        end
        XFER: begin
          if (abort) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            mem_cs_reg   <= 1'b1;
            mem_wr_reg   <= 1'b0;
            mem_data_reg <= '0;
          end else if (cyc_reg == LAST_XFER) begin
            cyc_reg      <= cyc_reg + 1'b1;
            mem_cs_reg   <= 1'b1;
            mem_wr_reg   <= 1'b0;
            mem_data_reg <= '0;
            // A store has nothing left to wait for. A load waits in DRAIN until its last byte arrives.
            if (op_reg || MEM_RD_LAT == 0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= DRAIN;
            end
          end else begin
            cyc_reg         <= cyc_reg + 1'b1;
            mem_address_reg <= mem_address_reg + 1'b1;
            if (mem_address_reg == ADDR_ONES) addr_wrap_reg <= 1'b1;
            mem_data_reg    <= op_reg ? word_byte(word_reg, cyc_reg + 1'b1) : 8'h00;
          end
        end
        DRAIN: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
            if (cyc_reg == LAST_DRAIN) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          if (!op_reg) rd_data_reg <= shadow_word;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign rd_data     = rd_data_reg;
  assign addr_wrap   = addr_wrap_reg;
  assign mem_address = mem_address_reg;
  assign mem_cs      = mem_cs_reg;
  assign mem_wr      = mem_wr_reg;
  assign mem_data    = mem_data_reg;

endmodule
